weight_update_accumulator: RTL

Upstream companion of the latched sign-magnitude weight register in the stochastic training datapath. It counts a positive and a negative stochastic gradient bitstream over a fixed window and scales the net count into a sign-magnitude delta. It adds the delta to the current weight, which is fed back from the register, with saturation. It then presents the new value on `MODIFIER`/`SIGN_MODIFIER` and issues a single `TRIG` pulse that loads the register.

---
 rtl/weight_update_accumulator.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/weight_update_accumulator.sv
// weight_update_accumulator
// Counts positive/negative stochastic gradient bitstreams over a 2^W sample
// window, scales the net count into a sign-magnitude delta, adds it to the
// fed-back weight with saturation and issues one TRIG pulse to load the
// downstream latched weight register.
//
// Ports
//   CLK           : clock, rising edge
//   INIT          : asynchronous active-high reset
//   EN            : enable for START acceptance and window sampling
//   START         : request an update window (sampled in IDLE only)
//   GRAD_POS      : positive-gradient bitstream
//   GRAD_NEG      : negative-gradient bitstream
//   WEIGHT        : current weight magnitude (N bits)
//   SIGN_WEIGHT   : current weight sign, 1 = negative
//   MODIFIER      : new weight magnitude, registered
//   SIGN_MODIFIER : new weight sign, registered
//   TRIG          : registered one-cycle load strobe
//   BUSY          : high whenever the FSM is not idle, registered
module weight_update_accumulator #(
   parameter int unsigned N     = 8,
   parameter int unsigned W     = 8,
   parameter int unsigned SHIFT = 2
) (
   input  logic         CLK,
   input  logic         INIT,
   input  logic         EN,
   input  logic         START,
   input  logic         GRAD_POS,
   input  logic         GRAD_NEG,
   input  logic [N-1:0] WEIGHT,
   input  logic         SIGN_WEIGHT,
   output logic [N-1:0] MODIFIER,
   output logic         SIGN_MODIFIER,
   output logic         TRIG,
   output logic         BUSY
);

   localparam int unsigned AW = W + 2;                       // signed accumulator
   localparam int unsigned MW = W + 1;                       // |acc| magnitude
   localparam int unsigned DW = ((MW > N) ? MW : N) + 1;     // clamp compare width
   localparam int unsigned SW = N + 1;                       // sum with carry
   localparam logic [N-1:0] MAX_MAG = {N{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      SCALE,
      COMPUTE,
      SETUP,
      PULSE
   } state_t;

   state_t         state, state_n;
   logic [W-1:0]   cnt, cnt_n;
   logic [AW-1:0]  acc, acc_n;
   logic [N-1:0]   dmag, dmag_n;
   logic           dsign, dsign_n;
   logic [N-1:0]   mod_n;
   logic           smod_n;
   logic           trig_n;
   logic           busy_n;

   logic [MW-1:0]  acc_abs;
   logic [MW-1:0]  acc_shr;
   logic [N-1:0]   dmag_clamped;
   logic [SW-1:0]  sum;
   logic [N-1:0]   new_mag;
   logic           new_sign;

   // Delta magnitude: |acc| scaled by the learning-rate shift, clamped to N bits
   always_comb begin
      acc_abs = acc[AW-1] ? MW'(-acc) : MW'(acc);
      acc_shr = acc_abs >> SHIFT;
      if (DW'(acc_shr) > DW'(MAX_MAG)) begin
         dmag_clamped = MAX_MAG;
      end else begin
         dmag_clamped = N'(acc_shr);
      end
   end

   // Sign-magnitude add of the registered delta to the fed-back weight
   always_comb begin
      sum      = SW'(WEIGHT) + SW'(dmag);
      new_mag  = '0;
      new_sign = 1'b0;
      if (SIGN_WEIGHT == dsign) begin
         new_mag  = sum[N] ? MAX_MAG : sum[N-1:0];
         new_sign = SIGN_WEIGHT && (new_mag != '0);
      end else if (dmag > WEIGHT) begin
         new_mag  = dmag - WEIGHT;
         new_sign = dsign;
      end else begin
         new_mag  = WEIGHT - dmag;
         new_sign = SIGN_WEIGHT && (new_mag != '0);
      end
   end

   // Next-state and next-register values
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      acc_n   = acc;
      dmag_n  = dmag;
      dsign_n = dsign;
      mod_n   = MODIFIER;
      smod_n  = SIGN_MODIFIER;
      trig_n  = 1'b0;
      case (state)
         IDLE: begin
            if (START && EN) begin
               cnt_n   = '0;
               acc_n   = '0;
               state_n = ACCUM;
            end
         end
         ACCUM: begin
            if (EN) begin
               if (GRAD_POS && !GRAD_NEG) begin
                  acc_n = acc + AW'(1);
               end else if (GRAD_NEG && !GRAD_POS) begin
                  acc_n = acc - AW'(1);
               end
               cnt_n = cnt + W'(1);
               // last sample of the window: counter is about to wrap
               if (cnt == {W{1'b1}}) begin
                  state_n = SCALE;
               end
            end
         end
         SCALE: begin
            dmag_n  = dmag_clamped;
            dsign_n = acc[AW-1] && (dmag_clamped != '0);
            state_n = COMPUTE;
         end
         COMPUTE: begin
            mod_n   = new_mag;
            smod_n  = new_sign;
            state_n = SETUP;
         end
         SETUP: begin
            trig_n  = 1'b1;
            state_n = PULSE;
         end
         PULSE: begin
            trig_n  = 1'b0;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   // State register
   always_ff @(posedge CLK or posedge INIT) begin
      if (INIT) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Datapath and output registers
   always_ff @(posedge CLK or posedge INIT) begin
      if (INIT) begin
         cnt           <= '0;
         acc           <= '0;
         dmag          <= '0;
         dsign         <= 1'b0;
         MODIFIER      <= '0;
         SIGN_MODIFIER <= 1'b0;
         TRIG          <= 1'b0;
         BUSY          <= 1'b0;
      end else begin
         cnt           <= cnt_n;
         acc           <= acc_n;
         dmag          <= dmag_n;
         dsign         <= dsign_n;
         MODIFIER      <= mod_n;
         SIGN_MODIFIER <= smod_n;
         TRIG          <= trig_n;
         BUSY          <= busy_n;
      end
   end

endmodule
